// File: rtl/game_state_ctrl_if.sv
// Bundles the game-logic stage's inputs (frame strobe, keycode, bird/pipe geometry)
// and its outputs (run enable, state, collision pulse, score digits).
interface game_state_ctrl_if;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic [9:0]  BallX;
    logic [9:0]  BallY;
    logic [9:0]  BallS;
    logic [9:0]  pipe1X;
    logic [9:0]  pipe1Y;
    logic [9:0]  pipe2X;
    logic [9:0]  pipe2Y;
    logic [9:0]  pipe3X;
    logic [9:0]  pipe3Y;
    logic        run;
    logic [1:0]  game_state;
    logic        collide;
    logic [9:0]  score_bin;
    logic [11:0] score_bcd;
    logic [11:0] hi_bcd;

    modport master (
        output frame_clk, keycode, BallX, BallY, BallS,
        output pipe1X, pipe1Y, pipe2X, pipe2Y, pipe3X, pipe3Y,
        input  run, game_state, collide, score_bin, score_bcd, hi_bcd
    );

    modport slave (
        input  frame_clk, keycode, BallX, BallY, BallS,
        input  pipe1X, pipe1Y, pipe2X, pipe2Y, pipe3X, pipe3Y,
        output run, game_state, collide, score_bin, score_bcd, hi_bcd
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Per-frame game logic: collision detection, pipe-cleared scoring with BCD and
// high-score tracking, and the IDLE/PLAY/DEAD sequencer driving the motion run enable.
module game_state_ctrl #(
    parameter logic [9:0] PIPE_W      = 10'd40,
    parameter logic [9:0] GAP_HALF    = 10'd50,
    parameter logic [9:0] FLOOR_Y     = 10'd460,
    parameter logic [7:0] START_KEY   = 8'h2C,
    parameter logic [7:0] DEAD_FRAMES = 8'd60
) (
    input  logic             Clk,
    input  logic             Reset_n,
    game_state_ctrl_if.slave bus
);

    localparam int unsigned GW = 11;
    localparam int unsigned NP = 3;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_DEAD = 2'b10;

    localparam logic [9:0]  SCORE_MAX = 10'd999;
    localparam logic [11:0] BCD_MAX   = 12'h999;

    logic [2:0]  fs;
    logic        tick;
    logic [7:0]  key_s1;
    logic [7:0]  key_s2;

    logic [1:0]    state, state_n;
    logic          run_r, run_n;
    logic          collide_r, collide_n;
    logic [9:0]    score, score_n;
    logic [11:0]   score_dec, score_dec_n;
    logic [11:0]   hi_dec, hi_dec_n;
    logic [9:0]    hi_score, hi_score_n;
    logic [NP-1:0] passed, passed_n;
    logic [7:0]    dead_cnt, dead_cnt_n;
    logic          key_prev, key_prev_n;

    logic [GW-1:0] bx, by, bs;
    logic [GW-1:0] px [NP];
    logic [GW-1:0] py [NP];
    logic [NP-1:0] hov, hit, past;
    logic          floor_hit;

    logic [NP-1:0] new_pass;
    logic [1:0]    inc;
    logic [9:0]    sum;
    logic          key_now;
    logic          key_hit;

    // One BCD increment of 0..3 with ones->tens->hundreds carry; caller keeps result below 999.
    function automatic logic [11:0] bcd_add(input logic [11:0] b, input logic [1:0] n);
        logic [3:0] o, t, h;
        o = b[3:0] + 4'(n);
        t = b[7:4];
        h = b[11:8];
        if (o > 4'd9) begin
            o = o - 4'd10;
            t = t + 4'd1;
        end
        if (t > 4'd9) begin
            t = t - 4'd10;
            h = h + 4'd1;
        end
        return {h, t, o};
    endfunction

    // frame_clk and keycode come from other clock domains; tick is a registered rising-edge pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs     <= '0;
            tick   <= 1'b0;
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            fs     <= {fs[1:0], bus.frame_clk};
            tick   <= fs[1] & ~fs[2];
            key_s1 <= bus.keycode;
            key_s2 <= key_s1;
        end
    end

    // Geometry widened to 11 bits and expressed with additions only so nothing underflows.
    always_comb begin
        bx    = GW'(bus.BallX);
        by    = GW'(bus.BallY);
        bs    = GW'(bus.BallS);
        px[0] = GW'(bus.pipe1X);
        px[1] = GW'(bus.pipe2X);
        px[2] = GW'(bus.pipe3X);
        py[0] = GW'(bus.pipe1Y);
        py[1] = GW'(bus.pipe2Y);
        py[2] = GW'(bus.pipe3Y);
        floor_hit = (by + bs) >= GW'(FLOOR_Y);
        hov  = '0;
        hit  = '0;
        past = '0;
        for (int i = 0; i < NP; i++) begin
            hov[i]  = ((bx + bs) >= px[i]) &&
                      (bx <= (px[i] + GW'(PIPE_W) - GW'(1) + bs));
            hit[i]  = hov[i] &&
                      (((by + GW'(GAP_HALF)) < (py[i] + bs)) ||
                       ((by + bs) > (py[i] + GW'(GAP_HALF))));
            past[i] = (px[i] + GW'(PIPE_W) + bs) <= bx;
        end
    end

    always_comb begin
        new_pass = past & ~passed;
        inc      = 2'(new_pass[0]) + 2'(new_pass[1]) + 2'(new_pass[2]);
        sum      = score + 10'(inc);
        key_now  = (key_s2 == START_KEY);
        key_hit  = key_now && !key_prev;
    end

    always_comb begin
        state_n     = state;
        collide_n   = 1'b0;
        score_n     = score;
        score_dec_n = score_dec;
        hi_dec_n    = hi_dec;
        hi_score_n  = hi_score;
        passed_n    = passed;
        dead_cnt_n  = dead_cnt;
        key_prev_n  = key_prev;

        if (tick) begin
            key_prev_n = key_now;
            case (state)
                ST_IDLE: begin
                    if (key_hit) begin
                        state_n     = ST_PLAY;
                        score_n     = '0;
                        score_dec_n = '0;
                        passed_n    = '0;
                        dead_cnt_n  = '0;
                    end
                end
                ST_PLAY: begin
                    // Collision wins over any pipe cleared on the same tick.
                    if ((|hit) || floor_hit) begin
                        state_n   = ST_DEAD;
                        collide_n = 1'b1;
                        if (score > hi_score) begin
                            hi_score_n = score;
                            hi_dec_n   = score_dec;
                        end
                    end else begin
                        // A pipe no longer past has wrapped to the right and may score again.
                        passed_n = past;
                        if (inc != 2'd0) begin
                            if (sum >= SCORE_MAX) begin
                                score_n     = SCORE_MAX;
                                score_dec_n = BCD_MAX;
                            end else begin
                                score_n     = sum;
                                score_dec_n = bcd_add(score_dec, inc);
                            end
                        end
                    end
                end
                ST_DEAD: begin
                    if (key_hit && (dead_cnt == DEAD_FRAMES)) begin
                        state_n = ST_IDLE;
                    end
                    if (dead_cnt != DEAD_FRAMES) begin
                        dead_cnt_n = dead_cnt + 8'd1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        run_n = (state_n == ST_PLAY);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            run_r     <= 1'b0;
            collide_r <= 1'b0;
            score     <= '0;
            score_dec <= '0;
            hi_dec    <= '0;
            hi_score  <= '0;
            passed    <= '0;
            dead_cnt  <= '0;
            key_prev  <= 1'b0;
        end else begin
            state     <= state_n;
            run_r     <= run_n;
            collide_r <= collide_n;
            score     <= score_n;
            score_dec <= score_dec_n;
            hi_dec    <= hi_dec_n;
            hi_score  <= hi_score_n;
            passed    <= passed_n;
            dead_cnt  <= dead_cnt_n;
            key_prev  <= key_prev_n;
        end
    end

    assign bus.run        = run_r;
    assign bus.game_state = state;
    assign bus.collide    = collide_r;
    assign bus.score_bin  = score;
    assign bus.score_bcd  = score_dec;
    assign bus.hi_bcd     = hi_dec;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Frame-level bench for game_state_ctrl: per-frame vectors queue their expected
// outputs, which are popped and compared once the frame tick has been processed.
module tb_game_state_ctrl;

    localparam logic [7:0] START = 8'h2C;
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] PLAY  = 2'b01;
    localparam logic [1:0] DEAD  = 2'b10;
    localparam int         FAR   = 600;

    typedef struct {
        logic [7:0] key;
        logic [9:0] bx, by, bs, p1x, p1y, p2x, p2y, p3x, p3y;
        logic [1:0] st;
        int         score;
        int         hi;
        int         ncol;
    } vec_t;

    typedef struct {
        string tag;
        int    st;
        int    run;
        int    score;
        int    bcd;
        int    hi;
        int    ncol;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_miss = 0;
    int   col_total = 0;
    exp_t sb[$];
    vec_t tbl_start[$];
    vec_t tbl_hit[$];

    always #5 Clk = ~Clk;

    game_state_ctrl_if bus();

    game_state_ctrl dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always @(negedge Clk) begin
        if (bus.collide === 1'b1) col_total++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic vec_t mkv(input logic [7:0] key, input int by, input int p1x, input int p1y,
                                 input int p2x, input int p3x, input logic [1:0] st,
                                 input int score, input int hi, input int ncol);
        vec_t v;
        v.key = key;
        v.bx  = 10'd100;
        v.by  = 10'(by);
        v.bs  = 10'd6;
        v.p1x = 10'(p1x);
        v.p1y = 10'(p1y);
        v.p2x = 10'(p2x);
        v.p2y = 10'd240;
        v.p3x = 10'(p3x);
        v.p3y = 10'd240;
        v.st  = st;
        v.score = score;
        v.hi  = hi;
        v.ncol = ncol;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.keycode = v.key;
        bus.BallX   = v.bx;
        bus.BallY   = v.by;
        bus.BallS   = v.bs;
        bus.pipe1X  = v.p1x;
        bus.pipe1Y  = v.p1y;
        bus.pipe2X  = v.p2x;
        bus.pipe2Y  = v.p2y;
        bus.pipe3X  = v.p3x;
        bus.pipe3Y  = v.p3y;
    endtask

    task automatic check_out(input int ncol);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_miss++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "/state"},   int'(bus.game_state), e.st);
        chk({e.tag, "/run"},     int'(bus.run),        e.run);
        chk({e.tag, "/score"},   int'(bus.score_bin),  e.score);
        chk({e.tag, "/bcd"},     int'(bus.score_bcd),  e.bcd);
        chk({e.tag, "/hi"},      int'(bus.hi_bcd),     e.hi);
        chk({e.tag, "/collide"}, ncol,                 e.ncol);
    endtask

    // One video frame: drive inputs, queue expectations, pulse frame_clk, compare.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        int   c0;
        @(negedge Clk);
        drive(v);
        e.tag   = tag;
        e.st    = int'(v.st);
        e.run   = (v.st == PLAY) ? 1 : 0;
        e.score = v.score;
        e.bcd   = int'(to_bcd(v.score));
        e.hi    = int'(to_bcd(v.hi));
        e.ncol  = v.ncol;
        sb.push_back(e);
        repeat (2) @(negedge Clk);
        c0 = col_total;
        bus.frame_clk = 1'b1;
        repeat (8) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check_out(col_total - c0);
    endtask

    // Holds DEAD for 60 frames (optional early key), then restarts through IDLE into PLAY.
    task automatic dead_wait(input int sc, input int hi, input int key_at);
        for (int k = 1; k <= 60; k++)
            apply(mkv((k == key_at) ? START : 8'h00, 240, FAR, 240, FAR, FAR, DEAD, sc, hi, 0),
                  $sformatf("dead_f%0d", k));
        apply(mkv(START, 240, FAR, 240, FAR, FAR, IDLE, sc, hi, 0), "dead_f61_key");
        apply(mkv(8'h00, 240, FAR, 240, FAR, FAR, IDLE, sc, hi, 0), "idle_release");
        apply(mkv(START, 240, FAR, 240, FAR, FAR, PLAY, 0, hi, 0), "replay");
    endtask

    initial begin
        int n;

        for (int i = 0; i < 9; i++) tbl_start.push_back(mkv(START, 240, 200, 240, FAR, FAR, PLAY, 0, 0, 0));
        tbl_start.push_back(mkv(8'h00, 240, 200, 240, FAR, FAR, PLAY, 0, 0, 0));
        tbl_hit.push_back(mkv(8'h00, 240, FAR, 240, FAR, FAR, PLAY, 1, 0, 0));
        tbl_hit.push_back(mkv(8'h00, 240, 98, 300, FAR, FAR, DEAD, 1, 1, 1));

        bus.frame_clk = 1'b0;
        drive(mkv(8'h00, 240, 200, 240, FAR, FAR, IDLE, 0, 0, 0));
        repeat (4) @(negedge Clk);
        chk("reset/state",   int'(bus.game_state), 0);
        chk("reset/run",     int'(bus.run),        0);
        chk("reset/collide", int'(bus.collide),    0);
        chk("reset/score",   int'(bus.score_bin),  0);
        chk("reset/bcd",     int'(bus.score_bcd),  0);
        chk("reset/hi",      int'(bus.hi_bcd),     0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Start frame measured by hand: run must rise 4 edges after frame_clk is sampled high.
        bus.keycode = START;
        repeat (2) @(negedge Clk);
        bus.frame_clk = 1'b1;
        n = 0;
        while (bus.run !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("start/latency", n, 4);
        repeat (4) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        chk("start/state", int'(bus.game_state), int'(PLAY));
        chk("start/score", int'(bus.score_bin), 0);

        foreach (tbl_start[i]) apply(tbl_start[i], $sformatf("hold_key%0d", i));

        for (int px = 200; px >= 40; px -= 4)
            apply(mkv(8'h00, 240, px, 240, FAR, FAR, PLAY, (px <= 52) ? 1 : 0, 0, 0),
                  $sformatf("sweep_px%0d", px));

        foreach (tbl_hit[i]) apply(tbl_hit[i], $sformatf("pipe_hit%0d", i));
        dead_wait(1, 1, 0);

        apply(mkv(8'h00, 455, FAR, 240, FAR, FAR, DEAD, 0, 1, 1), "floor_hit");
        dead_wait(0, 1, 30);

        for (int i = 0; i < 332; i++) begin
            apply(mkv(8'h00, 240, 0, 240, 0, 0, PLAY, 3 * (i + 1), 1, 0), "sat_pass3");
            apply(mkv(8'h00, 240, FAR, 240, FAR, FAR, PLAY, 3 * (i + 1), 1, 0), "sat_clear");
        end
        apply(mkv(8'h00, 240, 0, 240, FAR, FAR, PLAY, 997, 1, 0), "sat_997");
        apply(mkv(8'h00, 240, FAR, 240, FAR, FAR, PLAY, 997, 1, 0), "sat_clear997");
        apply(mkv(8'h00, 240, 0, 240, FAR, FAR, PLAY, 998, 1, 0), "sat_998");
        apply(mkv(8'h00, 240, FAR, 240, FAR, FAR, PLAY, 998, 1, 0), "sat_clear998");
        apply(mkv(8'h00, 240, 0, 240, 0, FAR, PLAY, 999, 1, 0), "sat_two_pipes");
        apply(mkv(8'h00, 240, FAR, 240, FAR, FAR, PLAY, 999, 1, 0), "sat_clear999");
        apply(mkv(8'h00, 240, 0, 240, 0, 0, PLAY, 999, 1, 0), "sat_hold");
        apply(mkv(8'h00, 455, FAR, 240, FAR, FAR, DEAD, 999, 999, 1), "sat_die");
        dead_wait(999, 999, 0);

        apply(mkv(8'h00, 240, 0, 240, FAR, FAR, PLAY, 1, 999, 0), "pre_reset_pass");

        // Reset dropped between clock edges must clear outputs without waiting for Clk.
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_rst/state",   int'(bus.game_state), 0);
        chk("async_rst/run",     int'(bus.run),        0);
        chk("async_rst/collide", int'(bus.collide),    0);
        chk("async_rst/score",   int'(bus.score_bin),  0);
        chk("async_rst/bcd",     int'(bus.score_bcd),  0);
        chk("async_rst/hi",      int'(bus.hi_bcd),     0);
        @(negedge Clk);
        Reset_n = 1'b1;
        apply(mkv(8'h00, 240, FAR, 240, FAR, FAR, IDLE, 0, 0, 0), "post_reset_idle");
        apply(mkv(START, 240, FAR, 240, FAR, FAR, PLAY, 0, 0, 0), "post_reset_start");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
